// File: rtl/vc_polarity_buffer.sv
// vc_polarity_buffer
// Two-virtual-channel flit buffer whose write and read sides alternate
// between the channels on every clock. In a cycle with polarity p, upstream
// may only write VC p (and only flits whose top bit equals p), while
// downstream may only read VC ~p. A channel is therefore never written and
// read in the same cycle.
// The downstream data port is called do_o because "do" is a reserved word
// in SystemVerilog.

module vc_polarity_buffer #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  si,
    input  logic [DATA_WIDTH-1:0] di,
    output logic                  ri,
    output logic                  so,
    output logic [DATA_WIDTH-1:0] do_o,
    input  logic                  ro,
    output logic                  polarity,
    output logic [CW-1:0]         cnt0,
    output logic [CW-1:0]         cnt1,
    output logic                  vc_err
);

    localparam int PW = $clog2(DEPTH);

    // Architectural state: index 0 is the even channel, index 1 the odd one
    logic                  polarity_q, polarity_d;
    logic [1:0][PW-1:0]    wrPtr_q, wrPtr_d;
    logic [1:0][PW-1:0]    rdPtr_q, rdPtr_d;
    logic [1:0][CW-1:0]    cnt_q, cnt_d;
    logic                  vcErr_q, vcErr_d;

    // Flit storage; its contents are only meaningful below each count
    logic [DATA_WIDTH-1:0] mem0 [DEPTH];
    logic [DATA_WIDTH-1:0] mem1 [DEPTH];

    logic                  wrVc;
    logic                  rdVc;
    logic                  vcMatch;
    logic                  wrEn;
    logic                  popEn;
    logic                  errSet;
    logic [DATA_WIDTH-1:0] headData;

    // Handshake and head-of-line selection; ri/so depend only on state
    always_comb begin
        wrVc     = polarity_q;
        rdVc     = ~polarity_q;
        ri       = (cnt_q[wrVc] < CW'(DEPTH));
        so       = (cnt_q[rdVc] != '0);
        headData = rdVc ? mem1[rdPtr_q[1]] : mem0[rdPtr_q[0]];
        do_o     = so ? headData : '0;
        vcMatch  = (di[DATA_WIDTH-1] == wrVc);
        wrEn     = si && ri && vcMatch;
        popEn    = so && ro;
        errSet   = si && !vcMatch;
    end

    // Next-state: write and pop always touch different channels
    always_comb begin
        polarity_d = ~polarity_q;
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        cnt_d      = cnt_q;
        vcErr_d    = vcErr_q | errSet;
        if (wrEn) begin
            wrPtr_d[wrVc] = wrPtr_q[wrVc] + PW'(1);
            cnt_d[wrVc]   = cnt_q[wrVc] + CW'(1);
        end
        if (popEn) begin
            rdPtr_d[rdVc] = rdPtr_q[rdVc] + PW'(1);
            cnt_d[rdVc]   = cnt_q[rdVc] - CW'(1);
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            polarity_q <= 1'b0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            cnt_q      <= '0;
            vcErr_q    <= 1'b0;
        end else begin
            polarity_q <= polarity_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            cnt_q      <= cnt_d;
            vcErr_q    <= vcErr_d;
        end
    end

    // Storage write into the tail of the channel owned by this polarity
    always_ff @(posedge clk) begin
        if (wrEn && !reset) begin
            if (wrVc) begin
                mem1[wrPtr_q[1]] <= di;
            end else begin
                mem0[wrPtr_q[0]] <= di;
            end
        end
    end

    assign polarity = polarity_q;
    assign cnt0     = cnt_q[0];
    assign cnt1     = cnt_q[1];
    assign vc_err   = vcErr_q;

endmodule

// File: tb/tb_vc_polarity_buffer.sv
// Directed testbench for vc_polarity_buffer (DATA_WIDTH=64, DEPTH=4).
// Inputs change #1 after each rising edge; outputs are compared there too.

module tb_vc_polarity_buffer;

    localparam int DW = 64;
    localparam int CW = 3;

    logic          clk;
    logic          reset;
    logic          si;
    logic [DW-1:0] di;
    logic          ri;
    logic          so;
    logic [DW-1:0] do_o;
    logic          ro;
    logic          polarity;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;
    logic          vc_err;

    int   checks;
    int   failures;
    logic expPol;

    vc_polarity_buffer #(
        .DATA_WIDTH(DW),
        .DEPTH     (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .si      (si),
        .di      (di),
        .ri      (ri),
        .so      (so),
        .do_o    (do_o),
        .ro      (ro),
        .polarity(polarity),
        .cnt0    (cnt0),
        .cnt1    (cnt1),
        .vc_err  (vc_err)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance one edge and confirm the polarity
    task automatic applyStimulus(input logic rst, input logic s, input logic [DW-1:0] d, input logic r);
        reset = rst;
        si    = s;
        di    = d;
        ro    = r;
        @(posedge clk);
        #1;
        expPol = rst ? 1'b0 : ~expPol;
        checkOutput("polarity", DW'(polarity), DW'(expPol));
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_ri"},   DW'(ri),   DW'(1'b1));
        checkOutput({tag, "_so"},   DW'(so),   DW'(1'b0));
        checkOutput({tag, "_do"},   do_o,      '0);
        checkOutput({tag, "_cnt0"}, DW'(cnt0), DW'(0));
        checkOutput({tag, "_cnt1"}, DW'(cnt1), DW'(0));
    endtask

    initial begin
        logic [DW-1:0] oddFlit;
        checks   = 0;
        failures = 0;
        expPol   = 1'b0;
        reset    = 1'b1;
        si       = 1'b0;
        di       = '0;
        ro       = 1'b0;

        // Reset for two cycles, then idle with polarity toggling
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        checkIdleOutputs("rst");
        checkOutput("rst_err", DW'(vc_err), DW'(1'b0));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0);
            checkIdleOutputs("idle");
        end

        // Single even flit: visible the next (odd) cycle, then popped
        applyStimulus(1'b0, 1'b1, 64'h0000_0000_0000_00AA, 1'b1);
        checkOutput("lat_so",   DW'(so),   DW'(1'b1));
        checkOutput("lat_do",   do_o,      64'h0000_0000_0000_00AA);
        checkOutput("lat_cnt0", DW'(cnt0), DW'(1));
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("pop_cnt0", DW'(cnt0), DW'(0));
        checkOutput("pop_so",   DW'(so),   DW'(1'b0));

        // Fill VC0 with 1..4 while downstream is stalled
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b0, 1'b1, DW'(k), 1'b0);
            checkOutput("fill_cnt0", DW'(cnt0), DW'(k));
            applyStimulus(1'b0, 1'b0, '0, 1'b0);
        end
        checkOutput("full_ri",   DW'(ri),   DW'(1'b0));
        checkOutput("full_cnt0", DW'(cnt0), DW'(4));
        applyStimulus(1'b0, 1'b1, 64'h5, 1'b0);
        checkOutput("drop_cnt0", DW'(cnt0), DW'(4));
        checkOutput("drop_err",  DW'(vc_err), DW'(1'b0));

        // Drain: heads appear only on odd cycles, in order
        for (int k = 1; k <= 4; k++) begin
            checkOutput("drain_so", DW'(so), DW'(1'b1));
            checkOutput("drain_do", do_o,    DW'(k));
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
            checkOutput("drain_even_so", DW'(so), DW'(1'b0));
            checkOutput("drain_cnt0",    DW'(cnt0), DW'(4 - k));
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
        end
        checkOutput("drained_so", DW'(so), DW'(1'b0));

        // Put two odd flits in VC1 (currently odd polarity)
        oddFlit = {1'b1, 63'h0C1};
        applyStimulus(1'b0, 1'b1, oddFlit, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1, {1'b1, 63'h0C2}, 1'b0);
        checkOutput("vc1_cnt1", DW'(cnt1), DW'(2));
        checkOutput("vc1_so",   DW'(so),   DW'(1'b1));
        checkOutput("vc1_do",   do_o,      oddFlit);

        // Even write into VC0 while VC1 pops in the same cycle
        applyStimulus(1'b0, 1'b1, 64'hB0, 1'b1);
        checkOutput("both_cnt1", DW'(cnt1), DW'(1));
        checkOutput("both_cnt0", DW'(cnt0), DW'(1));

        // Build cnt0=3, cnt1=2 then reset with traffic pending
        applyStimulus(1'b0, 1'b1, {1'b1, 63'h0C3}, 1'b0);
        applyStimulus(1'b0, 1'b1, 64'hB1, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1, 64'hB2, 1'b0);
        checkOutput("pre_cnt0", DW'(cnt0), DW'(3));
        checkOutput("pre_cnt1", DW'(cnt1), DW'(2));
        applyStimulus(1'b1, 1'b1, {1'b1, 63'h0C4}, 1'b1);
        checkIdleOutputs("midrst");

        // VC mismatch sets a sticky error that only reset clears
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1, {1'b1, 63'h0E0}, 1'b0);
        checkOutput("err_set",  DW'(vc_err), DW'(1'b1));
        checkOutput("err_cnt0", DW'(cnt0),   DW'(0));
        checkOutput("err_cnt1", DW'(cnt1),   DW'(0));
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("err_sticky", DW'(vc_err), DW'(1'b1));
        checkOutput("err_so",     DW'(so),     DW'(1'b0));
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        checkOutput("err_clear", DW'(vc_err), DW'(1'b0));
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkIdleOutputs("end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vc_polarity_buffer.md
VC_POLARITY_BUFFER -- requirements
Module: vc_polarity_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning flit width; VC select bit is DATA_WIDTH-1.
REQ-002 SHALL have parameter DEPTH, default 4, meaning entries per virtual channel (VC); legal values are powers of two, 2 or greater.
REQ-003 SHALL use ports as listed; CW = $clog2(DEPTH+1).
REQ-004 clk  input  1  the only clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 si  input  1  upstream send strobe; flit on di is valid.
REQ-007 di  input  DATA_WIDTH  upstream flit.
REQ-008 ri  output  1  ready to upstream for the VC equal to the current polarity.
REQ-009 so  output  1  downstream send strobe; flit on do is valid.
REQ-010 do  output  DATA_WIDTH  head flit of the read-side VC; all zeros when so=0.
REQ-011 ro  input  1  downstream ready.
REQ-012 polarity  output  1  current cycle polarity: 0 = even, 1 = odd.
REQ-013 cnt0, cnt1  output  CW each  occupancy of VC0 (even) and VC1 (odd).
REQ-014 vc_err  output  1  sticky error flag for a VC-mismatched write.

Function
REQ-015 polarity SHALL toggle every clock cycle.
REQ-016 Two independent circular FIFOs SHALL exist, VC0 and VC1, each DEPTH x DATA_WIDTH, with separate read pointers, write pointers and counts.
REQ-017 Write side: in a cycle with polarity=p, only VC p SHALL be writable; ri = (cnt_p < DEPTH).
REQ-018 A write SHALL occur when si=1, ri=1 and di[DATA_WIDTH-1]=p; the flit goes to the VC p tail and cnt_p increments.
REQ-019 If si=1 and di[DATA_WIDTH-1]!=p: flit dropped, no state change except vc_err set to 1 (sticky).
REQ-020 If si=1 and ri=0 (VC p full): flit dropped silently; upstream is required to honour ri; vc_err unchanged.
REQ-021 Read side: in a cycle with polarity=p, only VC ~p SHALL be readable; so = (cnt_~p > 0); do = head of VC ~p.
REQ-022 A pop SHALL occur when so=1 and ro=1; the VC ~p read pointer advances and cnt_~p decrements.
REQ-023 A VC SHALL never be written and read in the same cycle; simultaneous write and pop always target different VCs, so each count changes by at most 1 per cycle.
REQ-024 Latency: a flit written in cycle N SHALL be offered on so/do in cycle N+1 at the earliest (polarity has flipped).
REQ-025 Pointers SHALL wrap modulo DEPTH; FIFO order SHALL be strict per VC.
REQ-026 so, do, ri and cnt* SHALL be derived from registered state and the current polarity only; no combinational path from si/di to ri, or from ro to so.

Reset
REQ-027 While reset=1 at a clock edge: polarity<=0, all pointers and counts <=0, vc_err<=0; FIFO storage need not be cleared.
REQ-028 During and after reset: ri=1, so=0, do=0, cnt0=cnt1=0, vc_err=0; flits held at reset are discarded.
REQ-029 Reset asserted mid-operation SHALL take effect at the next edge regardless of si/ro; any in-progress write or pop in that cycle is discarded.

Verification
REQ-030 Reset 2 cycles, then idle -> polarity toggles 0,1,0,1...; ri=1, so=0, do=0, cnt0=cnt1=0.
REQ-031 polarity=0: send di=64'h0000_0000_0000_00AA (bit63=0), ro=1 -> next cycle so=1, do=64'h..00AA; cycle after that cnt0=0.
REQ-032 ro=0; write 4 even flits 0x1..0x4 on successive even cycles -> cnt0=4, ri=0 on even cycles; a 5th even flit is dropped; set ro=1 -> outputs 0x1,0x2,0x3,0x4 on odd cycles only.
REQ-033 polarity=0: send di with bit63=1 -> vc_err=1 persists, cnt0=cnt1=0; only reset clears it.
REQ-034 VC1 holds 2 flits while an even write hits VC0 with ro=1 in the same cycle -> cnt1 decrements by 1 and cnt0 increments by 1.
REQ-035 Assert reset with cnt0=3 and cnt1=2 -> next cycle all counts 0, so=0, polarity=0, ri=1.
